compare_bist: RTL

Built-in self-test engine for the `n_bit_compare` comparator.
- Sweeps every `{b, a}` operand pair exhaustively and drives the pair onto the comparator inputs.
- After a settle interval, samples `eq`/`lt`/`gt` and checks them against an internally computed golden result.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the comparator in the ALU block and serves as its on-chip stimulus/checker counterpart.

---
 rtl/compare_bist_if.sv | 27 ++
 rtl/compare_bist.sv | 118 +++++++++++
 2 files changed

// File: rtl/compare_bist_if.sv
// Operand/result bundle between the BIST engine and the n_bit_compare comparator.
// The master drives the operand pair and reads back the three compare flags.
interface compare_bist_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output a,
        output b,
        input  eq,
        input  lt,
        input  gt
    );

    modport slave (
        input  a,
        input  b,
        output eq,
        output lt,
        output gt
    );
endinterface

// File: rtl/compare_bist.sv
// Exhaustive self-test sweep for the n_bit_compare comparator: applies every {b, a} pair,
// checks eq/lt/gt against a golden unsigned compare and records a pass/fail summary.
module compare_bist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    compare_bist_if.master       cmp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int unsigned VW = 2 * WIDTH;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } state_e;

    state_e          state;
    logic [VW-1:0]   vec;
    logic [CW-1:0]   settle_cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]      golden;
    logic [2:0]      observed;
    logic            mismatch;

    // Operands come straight from the registered vector counter, so a/b are glitch-free.
    assign op_a  = vec[WIDTH-1:0];
    assign op_b  = vec[VW-1:WIDTH];
    assign cmp.a = op_a;
    assign cmp.b = op_b;

    assign golden   = {op_a == op_b, op_a < op_b, op_a > op_b};
    assign observed = {cmp.eq, cmp.lt, cmp.gt};
    assign mismatch = (golden != observed);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    if (settle_cnt == '0) begin
                        state <= StCheck;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= op_a;
                            fail_b     <= op_b;
                        end
                    end
                    if (vec == '1) begin
                        state <= StDone;
                    end else begin
                        vec        <= vec + VW'(1);
                        settle_cnt <= SETTLE_LOAD;
                        state      <= StWait;
                    end
                end
                StDone: begin
                    // err_count already includes the final vector's CHECK result here.
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
